// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed scanner for a common-segment hex display
// bank. Shows one digit at a time with an all-off guard gap between digits,
// blanks leading zeros on request, and swaps in new values only at frame
// boundaries so a frame never mixes old and new digits.
module hex_scan_driver #(
   parameter int DIGITS = 4,
   parameter int DWELL  = 1024,
   parameter int GAP    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  lz_en,
   output logic [3:0]            nibble,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  blank,
   output logic                  frame_tick
);

   localparam int CMAX0    = (DWELL > GAP) ? DWELL : GAP;
   localparam int CMAX     = (CMAX0 > 2) ? CMAX0 : 2;
   localparam int CW       = $clog2(CMAX);
   localparam int IW       = $clog2(DIGITS);
   localparam int GAP_M1   = (GAP > 0) ? GAP - 1 : 0;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_M1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   typedef enum logic {
      PH_SHOW,
      PH_GAP
   } phase_t;

   phase_t                phase;
   logic [IW-1:0]         idx;
   logic [CW-1:0]         cnt;
   logic [4*DIGITS-1:0]   disp;
   logic [4*DIGITS-1:0]   shadow;
   logic                  pending;

   logic                  advance;
   logic                  commit;
   logic                  hi_zero;

   // Decide whether this edge moves to the next digit and whether it wraps the frame
   always_comb begin
      advance = 1'b0;
      if (phase == PH_SHOW) begin
         advance = (cnt == DWELL_LAST) && (GAP == 0);
      end else begin
         advance = (cnt == GAP_LAST);
      end
      commit = advance && (idx == IDX_LAST);
   end

   // Phase/digit sequencing plus shadow-register load and frame-boundary commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase      <= PH_SHOW;
         idx        <= '0;
         cnt        <= '0;
         disp       <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         case (phase)
            PH_SHOW: begin
               if (cnt == DWELL_LAST) begin
                  cnt <= '0;
                  if (GAP > 0) begin
                     phase <= PH_GAP;
                  end else begin
                     idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PH_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  phase <= PH_SHOW;
                  idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               phase <= PH_SHOW;
               cnt   <= '0;
            end
         endcase

         frame_tick <= commit;

         // A load landing on the commit edge bypasses the shadow and goes
         // straight to display; otherwise it waits in the shadow.
         if (commit) begin
            if (load) begin
               disp <= value;
            end else if (pending) begin
               disp <= shadow;
            end
            pending <= 1'b0;
         end else if (load) begin
            shadow  <= value;
            pending <= 1'b1;
         end
      end
   end

   // Output decode from registered state; lz_en is the only input reaching an output
   always_comb begin
      nibble   = '0;
      digit_en = '0;
      hi_zero  = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (32'(idx) == k) begin
            nibble = disp[4*k +: 4];
            if (phase == PH_SHOW) begin
               digit_en[k] = 1'b1;
            end
         end
         if ((k >= 32'(idx)) && (disp[4*k +: 4] != 4'h0)) begin
            hi_zero = 1'b0;
         end
      end
      blank = (phase == PH_GAP) || (lz_en && (idx != '0) && hi_zero);
   end

endmodule
